// File: rtl/dcf77_pulse_decoder_pkg.sv
// Shared definitions for the DCF77 pulse decoder: state encodings, default
// thresholds (in 1 ms ticks), counter width and frame length.
package dcf77_pulse_decoder_pkg;

   localparam int CNT_W     = 12;
   localparam int FRAME_LEN = 59;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PULSE = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   localparam int DEF_DEBOUNCE   = 3;
   localparam int DEF_ZERO_MIN   = 40;
   localparam int DEF_ZERO_MAX   = 140;
   localparam int DEF_ONE_MIN    = 150;
   localparam int DEF_ONE_MAX    = 250;
   localparam int DEF_MINUTE_GAP = 1500;
   localparam int DEF_LOST_GAP   = 2500;

   // Counters stick at all-ones so a very long phase never wraps back into range.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/dcf77_input_filter.sv
// Synchronises the raw receiver output and debounces it on the 1 kHz tick.
// rise/fall are combinational strobes valid in the very tick cycle on which a
// new level is accepted, so the decoder can register its outputs directly.
module dcf77_input_filter #(
   parameter int DEBOUNCE = 3
) (
   input  logic clk_in,
   input  logic reset_n,
   input  logic tick,
   input  logic dcf_in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam logic [DW-1:0] LAST_AGREE = DW'(DEBOUNCE - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic [DW-1:0] agree_cnt;
   logic          accept;

   assign accept = tick && (sync_q2 != level) && (agree_cnt == LAST_AGREE);
   assign rise   = accept && sync_q2;
   assign fall   = accept && !sync_q2;

   // Two-flop synchroniser for the asynchronous receiver output.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= dcf_in;
         sync_q2 <= sync_q1;
      end
   end

   // Accept a new level only after DEBOUNCE consecutive ticks disagree with the current one.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         level     <= 1'b0;
         agree_cnt <= '0;
      end else if (tick) begin
         if (sync_q2 == level) begin
            agree_cnt <= '0;
         end else if (accept) begin
            level     <= sync_q2;
            agree_cnt <= '0;
         end else begin
            agree_cnt <= agree_cnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/dcf77_pulse_decoder.sv
// DCF77 pulse decoder: turns the filtered receiver level into second marks
// (sincro_out), minute marks, classified data bits and the second index.
module dcf77_pulse_decoder
   import dcf77_pulse_decoder_pkg::*;
#(
   parameter int DEBOUNCE   = DEF_DEBOUNCE,
   parameter int ZERO_MIN   = DEF_ZERO_MIN,
   parameter int ZERO_MAX   = DEF_ZERO_MAX,
   parameter int ONE_MIN    = DEF_ONE_MIN,
   parameter int ONE_MAX    = DEF_ONE_MAX,
   parameter int MINUTE_GAP = DEF_MINUTE_GAP,
   parameter int LOST_GAP   = DEF_LOST_GAP
) (
   input  logic       clk_in,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       dcf_in,
   output logic       sincro_out,
   output logic       minute_mark,
   output logic       bit_valid,
   output logic       bit_value,
   output logic [5:0] bit_index,
   output logic       frame_error,
   output logic       synced
);

   localparam int MW = CNT_W + 1;
   localparam logic [MW-1:0] ZERO_MIN_W   = MW'(ZERO_MIN);
   localparam logic [MW-1:0] ZERO_MAX_W   = MW'(ZERO_MAX);
   localparam logic [MW-1:0] ONE_MIN_W    = MW'(ONE_MIN);
   localparam logic [MW-1:0] ONE_MAX_W    = MW'(ONE_MAX);
   localparam logic [MW-1:0] MINUTE_GAP_W = MW'(MINUTE_GAP);
   localparam logic [MW-1:0] LOST_GAP_W   = MW'(LOST_GAP);
   localparam logic [5:0]    LAST_INDEX   = 6'(FRAME_LEN - 1);

   logic             filt_level;
   logic             filt_rise;
   logic             filt_fall;
   logic [1:0]       state;
   logic [CNT_W-1:0] width_cnt;
   logic [CNT_W-1:0] gap_cnt;
   logic [MW-1:0]    width_meas;
   logic [MW-1:0]    gap_meas;
   logic             is_zero;
   logic             is_one;

   dcf77_input_filter #(
      .DEBOUNCE (DEBOUNCE)
   ) u_filter (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .tick    (tick),
      .dcf_in  (dcf_in),
      .level   (filt_level),
      .rise    (filt_rise),
      .fall    (filt_fall)
   );

   // Measured lengths include the tick on which the closing edge is accepted.
   assign width_meas = {1'b0, width_cnt} + MW'(1);
   assign gap_meas   = {1'b0, gap_cnt} + MW'(1);
   assign is_zero    = (width_meas >= ZERO_MIN_W) && (width_meas <= ZERO_MAX_W);
   assign is_one     = (width_meas >= ONE_MIN_W) && (width_meas <= ONE_MAX_W);

   // FSM, phase counters, second indexing and bit classification.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         width_cnt   <= '0;
         gap_cnt     <= '0;
         sincro_out  <= 1'b0;
         minute_mark <= 1'b0;
         bit_valid   <= 1'b0;
         bit_value   <= 1'b0;
         bit_index   <= '0;
         frame_error <= 1'b0;
         synced      <= 1'b0;
      end else begin
         sincro_out  <= 1'b0;
         minute_mark <= 1'b0;
         bit_valid   <= 1'b0;
         frame_error <= 1'b0;
         if (filt_rise) begin
            state      <= ST_PULSE;
            width_cnt  <= '0;
            sincro_out <= 1'b1;
            if ((state == ST_GAP) && (gap_meas >= MINUTE_GAP_W)) begin
               minute_mark <= 1'b1;
               bit_index   <= '0;
               synced      <= 1'b1;
            end else if (bit_index == LAST_INDEX) begin
               frame_error <= 1'b1;
               synced      <= 1'b0;
            end else begin
               bit_index <= bit_index + 6'd1;
            end
         end else if (filt_fall && (state == ST_PULSE)) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
            if (is_zero || is_one) begin
               bit_value <= is_one;
               bit_valid <= synced;
            end else begin
               frame_error <= 1'b1;
               synced      <= 1'b0;
            end
         end else if (tick) begin
            if ((state == ST_PULSE) && filt_level) begin
               width_cnt <= sat_inc(width_cnt);
            end else if (state == ST_GAP) begin
               gap_cnt <= sat_inc(gap_cnt);
               if (gap_meas >= LOST_GAP_W) begin
                  state  <= ST_IDLE;
                  synced <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dcf77_pulse_decoder.sv
// Scoreboard bench for dcf77_pulse_decoder: stimulus pushes the expected event
// records, a negedge monitor pops and compares whenever the DUT emits a pulse.
module tb_dcf77_pulse_decoder;
   import dcf77_pulse_decoder_pkg::*;

   logic       clk_in  = 1'b0;
   logic       reset_n = 1'b1;
   logic       tick    = 1'b0;
   logic       dcf_in  = 1'b1;
   logic       sincro_out;
   logic       minute_mark;
   logic       bit_valid;
   logic       bit_value;
   logic [5:0] bit_index;
   logic       frame_error;
   logic       synced;

   logic [11:0] exp_q[$];
   logic [11:0] mon_act;
   logic [11:0] mon_exp;
   int          tests_run    = 0;
   int          tests_failed = 0;
   int          events_seen  = 0;

   dcf77_pulse_decoder dut (
      .clk_in      (clk_in),
      .reset_n     (reset_n),
      .tick        (tick),
      .dcf_in      (dcf_in),
      .sincro_out  (sincro_out),
      .minute_mark (minute_mark),
      .bit_valid   (bit_valid),
      .bit_value   (bit_value),
      .bit_index   (bit_index),
      .frame_error (frame_error),
      .synced      (synced)
   );

   // 100 MHz clock.
   always #5 clk_in = ~clk_in;

   // Tick strobe every second clock, changing on the falling edge.
   initial begin
      forever begin
         @(negedge clk_in);
         tick = 1'b1;
         @(negedge clk_in);
         tick = 1'b0;
      end
   end

   // Event record: {sincro, minute, valid, value (only if valid), frame_error, index, synced}.
   function automatic logic [11:0] ev(input logic s, input logic m, input logic v,
                                      input logic val, input logic fe,
                                      input logic [5:0] idx, input logic sy);
      return {s, m, v, v & val, fe, idx, sy};
   endfunction

   task automatic expect_rise(input logic m, input logic fe, input logic [5:0] idx,
                              input logic sy);
      exp_q.push_back(ev(1'b1, m, 1'b0, 1'b0, fe, idx, sy));
   endtask

   task automatic expect_fall(input logic val, input logic fe, input logic [5:0] idx,
                              input logic sy);
      exp_q.push_back(ev(1'b0, 1'b0, !fe, val, fe, idx, sy));
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) @(posedge tick);
   endtask

   // One pulse of the given width followed by a low phase, both in ticks.
   task automatic apply_stimulus(input int width, input int gap);
      dcf_in = 1'b1;
      wait_ticks(width);
      dcf_in = 1'b0;
      wait_ticks(gap);
   endtask

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Monitor: every emitted pulse must match the oldest pending expectation.
   always @(negedge clk_in) begin
      if (reset_n && (sincro_out || minute_mark || bit_valid || frame_error)) begin
         mon_act = ev(sincro_out, minute_mark, bit_valid, bit_value, frame_error,
                      bit_index, synced);
         events_seen++;
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_event: got %b, expected none at %0t", mon_act, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               tests_failed++;
               $display("[TB] FAIL event: got %b, expected %b at %0t", mon_act, mon_exp, $time);
            end
         end
      end
   end

   initial begin
      // Reset with the receiver output high.
      #2 reset_n = 1'b0;
      repeat (10) @(negedge clk_in);
      check_output("rst_sincro", 32'(sincro_out), 0);
      check_output("rst_minute", 32'(minute_mark), 0);
      check_output("rst_valid", 32'(bit_valid), 0);
      check_output("rst_value", 32'(bit_value), 0);
      check_output("rst_index", 32'(bit_index), 0);
      check_output("rst_ferr", 32'(frame_error), 0);
      check_output("rst_synced", 32'(synced), 0);
      dcf_in  = 1'b0;
      reset_n = 1'b1;

      // Glitches of one and two ticks must be invisible.
      wait_ticks(20);
      apply_stimulus(1, 20);
      apply_stimulus(2, 20);
      check_output("glitch_events", 32'(events_seen), 0);
      check_output("glitch_state", 32'(dut.state), 32'(ST_IDLE));

      // First pulse from IDLE: second mark only, no bit while unsynced.
      expect_rise(1'b0, 1'b0, 6'd1, 1'b0);
      apply_stimulus(100, 1800);

      // Minute mark after 1800 ms low, then a zero bit.
      expect_rise(1'b1, 1'b0, 6'd0, 1'b1);
      expect_fall(1'b0, 1'b0, 6'd0, 1'b1);
      apply_stimulus(100, 900);

      // A one bit.
      expect_rise(1'b0, 1'b0, 6'd1, 1'b1);
      expect_fall(1'b1, 1'b0, 6'd1, 1'b1);
      apply_stimulus(200, 800);

      // Widths between classes and above the one class are errors.
      expect_rise(1'b0, 1'b0, 6'd2, 1'b1);
      expect_fall(1'b0, 1'b1, 6'd2, 1'b0);
      apply_stimulus(145, 855);
      expect_rise(1'b0, 1'b0, 6'd3, 1'b0);
      expect_fall(1'b0, 1'b1, 6'd3, 1'b0);
      apply_stimulus(300, 1600);
      check_output("err_synced", 32'(synced), 0);

      // Resync, then run past second 58 without a minute gap.
      expect_rise(1'b1, 1'b0, 6'd0, 1'b1);
      expect_fall(1'b0, 1'b0, 6'd0, 1'b1);
      apply_stimulus(60, 100);
      for (int i = 1; i <= 58; i++) begin
         expect_rise(1'b0, 1'b0, 6'(i), 1'b1);
         expect_fall(1'b0, 1'b0, 6'(i), 1'b1);
         apply_stimulus(60, 100);
      end
      expect_rise(1'b0, 1'b1, 6'd58, 1'b0);
      apply_stimulus(60, 1600);
      check_output("overflow_index", 32'(bit_index), 58);
      check_output("overflow_synced", 32'(synced), 0);

      // Resync, then lose the signal with a 2600 ms low.
      expect_rise(1'b1, 1'b0, 6'd0, 1'b1);
      expect_fall(1'b0, 1'b0, 6'd0, 1'b1);
      apply_stimulus(60, 2600);
      check_output("lost_synced", 32'(synced), 0);
      check_output("lost_state", 32'(dut.state), 32'(ST_IDLE));
      expect_rise(1'b0, 1'b0, 6'd1, 1'b0);
      apply_stimulus(60, 1600);
      expect_rise(1'b1, 1'b0, 6'd0, 1'b1);
      expect_fall(1'b0, 1'b0, 6'd0, 1'b1);
      apply_stimulus(60, 300);

      // Reset in the middle of a pulse.
      expect_rise(1'b0, 1'b0, 6'd1, 1'b1);
      dcf_in = 1'b1;
      wait_ticks(50);
      check_output("pre_reset_pending", 32'(exp_q.size()), 0);
      reset_n = 1'b0;
      #1;
      check_output("mid_rst_sincro", 32'(sincro_out), 0);
      check_output("mid_rst_index", 32'(bit_index), 0);
      check_output("mid_rst_synced", 32'(synced), 0);
      check_output("mid_rst_value", 32'(bit_value), 0);
      check_output("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
      repeat (4) @(negedge clk_in);
      reset_n = 1'b1;
      expect_rise(1'b0, 1'b0, 6'd1, 1'b0);
      wait_ticks(48);
      dcf_in = 1'b0;
      wait_ticks(200);
      check_output("final_synced", 32'(synced), 0);
      check_output("queue_drained", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
